packet_transmitter: RTL and testbench

Transmit end of the inter-node packet link. Accepts one complete packet per handshake from packet_controller: a header flit, 1..MAX_FLITS data flits and a length. Serialises it onto a flit-wide valid/ready link as header, data, checksum. The receiving node's deserialiser consumes this stream, and packet_controller owns packet semantics.

---
 rtl/packet_transmitter_pkg.sv | 17 +
 rtl/packet_transmitter_checksum.sv | 31 +++
 rtl/packet_transmitter.sv | 162 ++++++++++++++++
 tb/tb_packet_transmitter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_transmitter_pkg.sv
// Shared types for the inter-node packet link.
// Flit width, packet limits and transmit FSM states.
package packet_types;

  localparam int FLIT_WIDTH = 32;
  localparam int MAX_FLITS  = 8;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY,
    CSUM
  } tx_state_e;

endpackage

// File: rtl/packet_transmitter_checksum.sv
// Running modular flit sum and its two's complement.
// Outputs include the flit being added this cycle.
module packet_checksum #(
  parameter int W = packet_types::FLIT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         add,
  input  logic [W-1:0] flit,
  output logic [W-1:0] sum,
  output logic [W-1:0] csum
);

  logic [W-1:0] acc;

  assign sum  = add ? acc + flit : acc;
  assign csum = ~sum + 1'b1;

  // Accumulator: cleared per packet, advances on each added flit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/packet_transmitter.sv
// Transmit end of the packet link.
// Serialises header, data flits and checksum.
module packet_transmitter #(
  parameter int FLIT_WIDTH = packet_types::FLIT_WIDTH,
  parameter int MAX_FLITS  = packet_types::MAX_FLITS,
  parameter int LEN_WIDTH  = $clog2(MAX_FLITS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pkt_valid,
  output logic                            pkt_ready,
  input  logic [LEN_WIDTH-1:0]            pkt_len,
  input  logic [FLIT_WIDTH-1:0]           pkt_header,
  input  logic [MAX_FLITS*FLIT_WIDTH-1:0] pkt_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic [FLIT_WIDTH-1:0]           tx_flit,
  output logic                            tx_last,
  output logic                            tx_busy,
  output logic                            err_len
);

  import packet_types::*;

  localparam int IDX_W = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;

  typedef logic [FLIT_WIDTH-1:0] word_t;

  tx_state_e            state;
  tx_state_e            state_n;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_n;
  logic [LEN_WIDTH-1:0] len_q;
  word_t                data_q [MAX_FLITS];
  word_t                flit_n;
  word_t                acc_sum;
  word_t                acc_csum;
  logic                 last_n;
  logic                 err_n;
  logic                 accept;
  logic                 hs;
  logic                 legal;
  logic                 acc_clr;
  logic                 acc_add;
  logic                 unused_sum;

  assign accept = pkt_valid & pkt_ready;
  assign hs     = tx_valid & tx_ready;
  assign legal  = (pkt_len != '0) &&
                  (pkt_len <= LEN_WIDTH'(MAX_FLITS));

  packet_checksum #(
    .W (FLIT_WIDTH)
  ) u_csum (
    .clk   (clk),
    .rst   (rst),
    .clear (acc_clr),
    .add   (acc_add),
    .flit  (tx_flit),
    .sum   (acc_sum),
    .csum  (acc_csum)
  );

  // The transmitter only needs the complement; sum serves the rx checker.
  assign unused_sum = ^acc_sum;

  // Next state, next flit and accumulator control.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    flit_n  = tx_flit;
    last_n  = tx_last;
    err_n   = 1'b0;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          acc_clr = 1'b1;
          if (legal) begin
            state_n = HEAD;
            flit_n  = pkt_header;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      HEAD: begin
        if (hs) begin
          acc_add = 1'b1;
          state_n = BODY;
          idx_n   = '0;
          flit_n  = data_q[0];
        end
      end
      BODY: begin
        if (hs) begin
          acc_add = 1'b1;
          if (LEN_WIDTH'(idx) == len_q - 1'b1) begin
            state_n = CSUM;
            flit_n  = acc_csum;
            last_n  = 1'b1;
          end else begin
            idx_n  = idx + 1'b1;
            flit_n = data_q[idx_n];
          end
        end
      end
      CSUM: begin
        if (hs) begin
          state_n = IDLE;
          flit_n  = '0;
          last_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered link/handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      len_q     <= '0;
      tx_valid  <= 1'b0;
      tx_busy   <= 1'b0;
      tx_flit   <= '0;
      tx_last   <= 1'b0;
      err_len   <= 1'b0;
      pkt_ready <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      tx_valid  <= (state_n != IDLE);
      tx_busy   <= (state_n != IDLE);
      tx_flit   <= flit_n;
      tx_last   <= last_n;
      err_len   <= err_n;
      pkt_ready <= (state_n == IDLE) && !err_n;
      if (accept) begin
        len_q <= pkt_len;
      end
    end
  end

  // Packet payload captured on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_FLITS; i++) begin
        data_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < MAX_FLITS; i++) begin
        data_q[i] <= pkt_data[i*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_packet_transmitter.sv
// Bench for packet_transmitter.
// Scoreboard of expected flits, checked at negedge.
module tb_packet_transmitter;

  import packet_types::*;

  localparam int FW = 32;
  localparam int MF = 8;
  localparam int LW = $clog2(MF + 1);

  typedef struct {
    flit_t flit;
    logic  last;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [LW-1:0]     pkt_len;
  logic [FW-1:0]     pkt_header;
  logic [MF*FW-1:0]  pkt_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [FW-1:0]     tx_flit;
  logic              tx_last;
  logic              tx_busy;
  logic              err_len;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks;
  int   n_errors;
  int   hs_cnt;

  packet_transmitter #(
    .FLIT_WIDTH (FW),
    .MAX_FLITS  (MF),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_len    (pkt_len),
    .pkt_header (pkt_header),
    .pkt_data   (pkt_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_flit    (tx_flit),
    .tx_last    (tx_last),
    .tx_busy    (tx_busy),
    .err_len    (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [FW-1:0] got,
                       input logic [FW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Link monitor: every valid flit must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid) begin
        check("busy", 32'(tx_busy), 32'd1);
        check("rdy_busy", 32'(pkt_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q[0];
          check("flit", tx_flit, mon_e.flit);
          check("last", 32'(tx_last), 32'(mon_e.last));
          if (tx_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end else begin
        check("last_idle", 32'(tx_last), 32'd0);
        check("busy_idle", 32'(tx_busy), 32'd0);
      end
    end
  end

  task automatic send_pkt(input logic [LW-1:0]    len,
                          input logic [FW-1:0]    hdr,
                          input logic [MF*FW-1:0] data);
    logic [FW-1:0] acc;
    logic [FW-1:0] d;
    bit            ok;
    bit            legal_m;
    legal_m = (len >= 1) && (len <= MF);
    if (legal_m) begin
      acc = hdr;
      exp_q.push_back('{flit: hdr, last: 1'b0});
      for (int i = 0; i < int'(len); i++) begin
        d = data[i*FW +: FW];
        acc = acc + d;
        exp_q.push_back('{flit: d, last: 1'b0});
      end
      exp_q.push_back('{flit: (~acc) + 32'd1, last: 1'b1});
    end
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pkt_ready) begin
        ok = 1;
        break;
      end
    end
    check("ready_wait", 32'(ok), 32'd1);
    pkt_len    = len;
    pkt_header = hdr;
    pkt_data   = data;
    pkt_valid  = 1'b1;
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    if (legal_m) begin
      check("acc_valid", 32'(tx_valid), 32'd1);
      check("acc_ready", 32'(pkt_ready), 32'd0);
    end else begin
      check("err_pulse", 32'(err_len), 32'd1);
      check("err_novalid", 32'(tx_valid), 32'd0);
      @(posedge clk);
      #1;
      check("err_clear", 32'(err_len), 32'd0);
      check("err_ready", 32'(pkt_ready), 32'd1);
      check("err_novalid2", 32'(tx_valid), 32'd0);
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && pkt_ready) begin
        ok = 1;
        break;
      end
    end
    check("drain", 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [MF*FW-1:0] d2;
    logic [MF*FW-1:0] d4;
    logic [7:0]       pat;
    int               base;
    bit               ok;

    n_checks   = 0;
    n_errors   = 0;
    hs_cnt     = 0;
    rst        = 1'b0;
    pkt_valid  = 1'b0;
    pkt_len    = '0;
    pkt_header = '0;
    pkt_data   = '0;
    tx_ready   = 1'b1;

    d2 = '0;
    d2[0*FW +: FW] = 32'h10;
    d2[1*FW +: FW] = 32'h20;
    d4 = '0;
    for (int i = 0; i < 4; i++) d4[i*FW +: FW] = 32'(i + 1) * 32'h111;

    // 1: reset, including an asynchronous mid-cycle assertion
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_ready", 32'(pkt_ready), 32'd0);
    check("rst_flit", tx_flit, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready_rel", 32'(pkt_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_up", 32'(pkt_ready), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(pkt_ready), 32'd0);
    check("mid_rst_err", 32'(err_len), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_up2", 32'(pkt_ready), 32'd1);

    // 2: basic two-flit packet, link always ready
    send_pkt(4'd2, 32'h0000_00A1, d2);
    wait_drain();

    // 3: same packet with stalls
    send_pkt(4'd2, 32'h0000_00A1, d2);
    base = hs_cnt;
    pat  = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      tx_ready = pat[i];
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b1;
    check("stall_hs", 32'(hs_cnt - base), 32'd4);
    wait_drain();

    // 4: illegal lengths
    send_pkt(4'd0, 32'hDEAD_0000, d2);
    send_pkt(4'd9, 32'hDEAD_0009, d2);

    // 5: maximum length with wrap-around checksum
    send_pkt(4'd8, 32'h0000_0001, '1);
    wait_drain();

    // 6: reset abort mid-packet, then a clean packet
    send_pkt(4'd4, 32'h0000_0055, d4);
    base = hs_cnt;
    ok   = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (hs_cnt >= base + 2) begin
        ok = 1;
        break;
      end
    end
    check("abort_wait", 32'(ok), 32'd1);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_last", 32'(tx_last), 32'd0);
    check("abort_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_pkt(4'd2, 32'h0000_00A1, d2);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
